// File: rtl/ahb_mem_wrapper.sv
// AHB-Lite slave wrapping a MEM_DEPTH x 32-bit single-cycle memory with byte-lane writes.
// Optional macro ERROR_RESP_EN: out-of-range addresses get a two-cycle ERROR response instead of wrapping.
`timescale 1ns/1ps
module ahb_mem_wrapper #(
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [1:0]  HTRANS,
    input  logic        HMASTLOCK,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);

    logic [31:0]   r_mem [MEM_DEPTH];

    logic          r_dp_valid;
    logic          r_dp_write;
    logic          r_dp_err;
    logic [AW-1:0] r_dp_idx;
    logic [3:0]    r_dp_be;

    logic          r_hreadyout;
    logic          r_hresp;
    logic [31:0]   r_rdata;

    logic          w_xfer;
    logic          w_err;
    logic          w_wr_commit;
    logic [AW-1:0] w_idx;
    logic [3:0]    w_be;
    logic [31:0]   w_fwd_word;
    logic          w_unused;

    assign w_xfer = HSEL & HREADY & HTRANS[1];
    assign w_idx  = HADDR[AW+1:2];

`ifdef ERROR_RESP_EN
    assign w_err = |HADDR[31:AW+2];
`else
    assign w_err = 1'b0;
`endif

    assign w_unused = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], HADDR[31:AW+2]};

    // Byte lanes; unaligned addresses align down, sizes above word act as word
    always_comb begin
        w_be = 4'b1111;
        case (HSIZE)
            3'd0:    w_be = 4'(4'b0001 << HADDR[1:0]);
            3'd1:    w_be = HADDR[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    assign w_wr_commit = r_dp_valid & r_dp_write & ~r_dp_err & HREADY;

    // A write completing this edge is merged into a read of the same word
    always_comb begin
        w_fwd_word = r_mem[w_idx];
        if (w_wr_commit && (r_dp_idx == w_idx)) begin
            for (int b = 0; b < 4; b++) begin
                if (r_dp_be[b]) begin
                    w_fwd_word[8*b +: 8] = HWDATA[8*b +: 8];
                end
            end
        end
    end

    // Memory array is deliberately not reset
    always_ff @(posedge HCLK) begin
        if (w_wr_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (r_dp_be[b]) begin
                    r_mem[r_dp_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_err   <= 1'b0;
            r_dp_idx   <= '0;
            r_dp_be    <= '0;
        end else if (HREADY) begin
            r_dp_valid <= w_xfer;
            r_dp_write <= HWRITE;
            r_dp_err   <= w_xfer & w_err;
            r_dp_idx   <= w_idx;
            r_dp_be    <= w_be;
        end
    end

    // Response: zero-wait OKAY, or ERROR with one low-HREADYOUT cycle first
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_rdata     <= '0;
        end else if (HREADY) begin
            r_hreadyout <= ~(w_xfer & w_err);
            r_hresp     <= w_xfer & w_err;
            r_rdata     <= (w_xfer & ~HWRITE & ~w_err) ? w_fwd_word : 32'h0;
        end else if (r_dp_err & ~r_hreadyout) begin
            r_hreadyout <= 1'b1;
        end
    end

    assign HRDATA    = r_rdata;
    assign HREADYOUT = r_hreadyout;
    assign HRESP     = r_hresp;

endmodule

// File: tb/tb_ahb_mem_wrapper.sv
// Scoreboard bench for ahb_mem_wrapper: directed scenarios plus random AHB traffic
// against a byte-array memory model; honours ERROR_RESP_EN when defined.
`timescale 1ns/1ps
module tb_ahb_mem_wrapper;

    localparam int unsigned DEPTH = 256;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = '0;
    logic [2:0]  HBURST = '0;
    logic [3:0]  HPROT = '0;
    logic [1:0]  HTRANS = '0;
    logic        HMASTLOCK = 1'b0;
    logic        HREADY;
    logic [31:0] HWDATA = '0;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    assign HREADY = HREADYOUT;

    ahb_mem_wrapper #(.MEM_DEPTH(DEPTH)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q[$];
    exp_t        me;
    logic        mon_wait = 1'b0;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] mem_m [DEPTH];
    logic [31:0] pend_wdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one address phase (plus previous write data), wait for acceptance, update model
    task automatic drive(input logic sel, input logic [1:0] tr, input logic wr,
                         input logic [2:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, input bit commit);
        logic rdy;
        int   n;
        int   nb;
        int   base;
        int   idx;
        exp_t e;
        HSEL = sel; HTRANS = tr; HWRITE = wr; HSIZE = sz; HADDR = addr;
        HWDATA = pend_wdata;
        HBURST = 3'($urandom_range(0, 7)); HPROT = 4'($urandom_range(0, 15));
        HMASTLOCK = 1'($urandom_range(0, 1));
        n = 0;
        rdy = 1'b0;
        while (!rdy) begin
            @(negedge HCLK);
            rdy = HREADYOUT;
            @(posedge HCLK);
            n++;
            if (!rdy && n > 8) begin
                tests++; fails++;
                $display("FAIL accept_timeout: address 0x%08h not accepted within 8 cycles", addr);
                rdy = 1'b1;
            end
        end
        #1;
        e.rdata = '0;
        e.err   = 1'b0;
        if (commit && sel && (tr == 2'd2 || tr == 2'd3)) begin
`ifdef ERROR_RESP_EN
            e.err = (addr >= 32'(4 * DEPTH));
`endif
            if (!e.err) begin
                idx  = int'((addr / 4) % DEPTH);
                nb   = (sz > 3'd2) ? 4 : (1 << sz);
                base = (int'(addr % 4) / nb) * nb;
                if (wr) begin
                    for (int b = base; b < base + nb; b++) mem_m[idx][8*b +: 8] = wd[8*b +: 8];
                end else begin
                    e.rdata = mem_m[idx];
                end
            end
        end
        if (commit) q.push_back(e);
        pend_wdata = wd;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 1'b0, 3'd0, 32'h0, 32'($urandom), 1'b1);
    endtask

    // Scoreboard monitor: one entry per data phase, consumed when HREADYOUT is high
    always @(negedge HCLK) begin
        if (HRESETn && q.size() > 0) begin
            if (!HREADYOUT) begin
                tests++;
                if (!(q[0].err && HRESP === 1'b1)) begin
                    fails++;
                    $display("FAIL wait_state: hresp=%0b with hreadyout=0, expected error entry=%0b", HRESP, q[0].err);
                end
                mon_wait = 1'b1;
            end else begin
                me = q.pop_front();
                check("hrdata", HRDATA, me.rdata);
                check("hresp", 32'(HRESP), 32'(me.err));
                if (me.err) check("err_first_cycle_seen", 32'(mon_wait), 32'd1);
                mon_wait = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [31:0] a;
        HSEL = 1'b1; HTRANS = 2'd2; HWRITE = 1'b1; HADDR = 32'h10; HWDATA = 32'hFFFF_FFFF;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        check("rst_hresp", 32'(HRESP), 32'd0);
        check("rst_hrdata", HRDATA, 32'd0);
        HSEL = 1'b0; HTRANS = 2'd0;
        HRESETn = 1'b1;

        for (int i = 0; i < int'(DEPTH); i++)
            drive(1'b1, (i == 0) ? 2'd2 : 2'd3, 1'b1, 3'd2, 32'(i * 4), 32'($urandom), 1'b1);

        drive(1'b1, 2'd2, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b1);
        drive(1'b1, 2'd2, 1'b0, 3'd2, 32'h10, 32'h0, 1'b1);

        drive(1'b1, 2'd2, 1'b1, 3'd2, 32'h20, 32'h0000_0000, 1'b1);
        drive(1'b1, 2'd2, 1'b1, 3'd0, 32'h21, 32'h0000_AB00, 1'b1);
        drive(1'b1, 2'd2, 1'b1, 3'd1, 32'h22, 32'h1234_0000, 1'b1);
        drive(1'b1, 2'd2, 1'b0, 3'd2, 32'h20, 32'h0, 1'b1);

        for (int i = 0; i < 4; i++)
            drive(1'b1, (i == 0) ? 2'd2 : 2'd3, 1'b1, 3'd2, 32'(i * 4), 32'(i + 1), 1'b1);
        for (int i = 0; i < 4; i++)
            drive(1'b1, (i == 0) ? 2'd2 : 2'd3, 1'b0, 3'd2, 32'(i * 4), 32'h0, 1'b1);

        drive(1'b1, 2'd2, 1'b1, 3'd2, 32'h40, 32'h0000_0055, 1'b1);
        drive(1'b1, 2'd2, 1'b0, 3'd2, 32'h40, 32'h0, 1'b1);

        drive(1'b1, 2'd0, 1'b1, 3'd2, 32'h10, 32'hFFFF_FFFF, 1'b1);
        drive(1'b0, 2'd2, 1'b1, 3'd2, 32'h10, 32'hFFFF_FFFF, 1'b1);
        drive(1'b1, 2'd1, 1'b1, 3'd2, 32'h10, 32'hFFFF_FFFF, 1'b1);
        drive(1'b1, 2'd2, 1'b0, 3'd2, 32'h10, 32'h0, 1'b1);

        drive(1'b1, 2'd2, 1'b1, 3'd3, 32'h53, 32'hA5A5_5A5A, 1'b1);
        drive(1'b1, 2'd2, 1'b1, 3'd1, 32'h61, 32'h7777_BEEF, 1'b1);
        drive(1'b1, 2'd2, 1'b0, 3'd2, 32'h50, 32'h0, 1'b1);
        drive(1'b1, 2'd2, 1'b0, 3'd2, 32'h60, 32'h0, 1'b1);

        drive(1'b1, 2'd2, 1'b1, 3'd2, 32'h400, 32'hCAFE_F00D, 1'b1);
        drive(1'b1, 2'd2, 1'b0, 3'd2, 32'h0, 32'h0, 1'b1);
        idle();

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'($urandom_range(1024, 4095));
                1:       a = 32'($urandom_range(0, 1023));
                default: a = 32'($urandom_range(0, 31));
            endcase
            drive(1'($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)), a,
                  32'($urandom), 1'b1);
        end
        idle();
        idle();

        drive(1'b1, 2'd2, 1'b1, 3'd2, 32'h80, 32'h1357_9BDF, 1'b0);
        HWDATA = 32'h1357_9BDF; HSEL = 1'b0; HTRANS = 2'd0;
        #1 HRESETn = 1'b0;
        @(negedge HCLK);
        check("abort_rst_hreadyout", 32'(HREADYOUT), 32'd1);
        check("abort_rst_hresp", 32'(HRESP), 32'd0);
        check("abort_rst_hrdata", HRDATA, 32'd0);
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        pend_wdata = '0;
        drive(1'b1, 2'd2, 1'b0, 3'd2, 32'h80, 32'h0, 1'b1);
        idle();
        idle();

        k = 0;
        while (q.size() != 0 && k < 20) begin
            @(posedge HCLK);
            k++;
        end
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_mem_wrapper.md
AHB_MEM_WRAPPER -- requirements
Module: ahb_mem_wrapper

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, meaning the number of 32-bit memory words (power of two, 1 KB default).
REQ-002 SHALL have port HCLK, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port HRESETn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port HSEL, input, 1 bit: slave select.
REQ-005 SHALL have port HADDR, input, 32 bits: byte address.
REQ-006 SHALL have port HWRITE, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port HSIZE, input, 3 bits: transfer size (0 = byte, 1 = halfword, 2 = word).
REQ-008 SHALL have port HBURST, input, 3 bits: burst type; accepted and ignored.
REQ-009 SHALL have port HPROT, input, 4 bits: protection; accepted and ignored.
REQ-010 SHALL have port HTRANS, input, 2 bits: IDLE = 0, BUSY = 1, NONSEQ = 2, SEQ = 3.
REQ-011 SHALL have port HMASTLOCK, input, 1 bit: locked transfer; accepted and ignored.
REQ-012 SHALL have port HREADY, input, 1 bit: bus-level ready (previous transfer complete).
REQ-013 SHALL have port HWDATA, input, 32 bits: write data, valid in the data phase.
REQ-014 SHALL have port HRDATA, output, 32 bits: read data.
REQ-015 SHALL have port HREADYOUT, output, 1 bit: slave ready.
REQ-016 SHALL have port HRESP, output, 1 bit: 0 = OKAY, 1 = ERROR.

Function
REQ-017 SHALL capture an address phase on a rising HCLK edge when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ, registering HADDR, HWRITE and HSIZE.
REQ-018 SHALL treat IDLE, BUSY, HSEL=0 or HREADY=0 as no transfer: no memory access, HREADYOUT=1, HRESP=OKAY.
REQ-019 SHALL address memory words by registered HADDR[log2(MEM_DEPTH)+1:2]; HADDR[1:0] selects byte lanes, little-endian (lane n = HWDATA[8n+7:8n]).
REQ-020 SHALL, for a write, update only the enabled lanes at the end of the data phase:
- byte: one lane, chosen by HADDR[1:0]
- halfword: lanes {HADDR[1],0} and {HADDR[1],1}
- word: all four lanes
REQ-021 SHALL align unaligned addresses down to the transfer size, and treat HSIZE > 2 as word.
REQ-022 SHALL complete reads with zero wait states: HRDATA presents the full addressed word during the data phase cycle following the address phase.
REQ-023 SHALL, for a read immediately following a write to the same word, return the newly written data with no stall.
REQ-024 SHALL drive HRDATA = 0 whenever no read data phase is active.
REQ-025 SHALL support back-to-back pipelined transfers (NONSEQ/SEQ every cycle) at one transfer per cycle for in-range addresses.

Reset
REQ-026 SHALL, while HRESETn=0, force HREADYOUT=1, HRESP=0 and HRDATA=0, and clear the pending data-phase state.
REQ-027 SHALL abort a transfer in progress when reset is asserted; no memory write occurs for it.
REQ-028 SHALL NOT reset memory contents.

Configuration
REQ-029 SHALL, with macro ERROR_RESP_EN defined, respond to an address with HADDR >= 4*MEM_DEPTH using the two-cycle AHB ERROR response:
- cycle 1: HREADYOUT=0, HRESP=1
- cycle 2: HREADYOUT=1, HRESP=1
- memory is unchanged and HRDATA=0
REQ-030 SHALL, without ERROR_RESP_EN, wrap out-of-range addresses modulo 4*MEM_DEPTH and always respond OKAY with zero wait states.

Verification
REQ-031 SHALL pass: reset, then word write 0xDEADBEEF to 0x10, then read 0x10 -> HRDATA=0xDEADBEEF, HRESP=0, HREADYOUT=1 throughout.
REQ-032 SHALL pass: word write 0x00000000 to 0x20, byte write 0xAB at 0x21, halfword write 0x1234 at 0x22 -> word read at 0x20 returns 0x1234AB00.
REQ-033 SHALL pass: pipelined NONSEQ+SEQ writes of 1, 2, 3, 4 to 0x0, 0x4, 0x8, 0xC, then a 4-beat read -> 1, 2, 3, 4 on consecutive cycles with no wait states.
REQ-034 SHALL pass: write 0x55 to 0x40 immediately followed by a read of 0x40 -> 0x00000055.
REQ-035 SHALL pass: an IDLE transfer with HWRITE=1 and HWDATA=0xFFFFFFFF to 0x10 -> memory unchanged, HRESP=0.
REQ-036 SHALL pass, with ERROR_RESP_EN, a write to 0x400 (MEM_DEPTH=256) -> HREADYOUT 0 then 1 with HRESP=1 in both cycles; without the macro, the write lands at 0x0.
